// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO controller.
// The optional error flags are enabled with the SYNC_FIFO_ERR_FLAG_EN macro.
package fifo_pkg;

  localparam int FIFO_AW = 4;

  function automatic int fifo_depth(input int addr_wd);
    return 1 << addr_wd;
  endfunction

  typedef logic [FIFO_AW:0] ptr_t;
  typedef logic [FIFO_AW:0] cnt_t;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and sync_fifo_ctrl.
// The master side issues push/pop requests; the slave side is the controller.
interface sync_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WD = FIFO_AW
);

  logic               winc;
  logic               rinc;
  logic               mem_winc;
  logic [ADDR_WD-1:0] waddr;
  logic [ADDR_WD-1:0] raddr;
  logic               wfull;
  logic               rempty;
  logic [ADDR_WD:0]   count;
  logic               almost_full;
  logic               almost_empty;
  logic               overflow;
  logic               underflow;

  modport master (
    output winc, rinc,
    input  mem_winc, waddr, raddr, wfull, rempty, count,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  winc, rinc,
    output mem_winc, waddr, raddr, wfull, rempty, count,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping binary pointer register with synchronous active-high reset and
// increment enable; used for both the write and the read pointer.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: owns the pointers, drives the mem write port
// and addresses, and reports full/empty/occupancy/thresholds. Optional sticky
// overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAG_EN is defined.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WD   = FIFO_AW,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_ctrl_if.slave     bus
);

  localparam int DEPTH = fifo_depth(ADDR_WD);
  localparam logic [ADDR_WD:0] AFULL_C  = (ADDR_WD+1)'((AFULL_TH > DEPTH) ? DEPTH : AFULL_TH);
  localparam logic [ADDR_WD:0] AEMPTY_C = (ADDR_WD+1)'(AEMPTY_TH);

  logic [ADDR_WD:0] w_wptr;
  logic [ADDR_WD:0] w_rptr;
  logic             w_wfull;
  logic             w_rempty;
  logic             w_we;
  logic             w_re;
  logic [ADDR_WD:0] r_count;

  // Flags come from the registered pointers, so they describe the state at
  // the start of the cycle; an extra MSB distinguishes full from empty.
  assign w_rempty = (w_wptr == w_rptr);
  assign w_wfull  = (w_wptr[ADDR_WD] != w_rptr[ADDR_WD]) &&
                    (w_wptr[ADDR_WD-1:0] == w_rptr[ADDR_WD-1:0]);

  assign w_we = bus.winc & ~w_wfull;
  assign w_re = bus.rinc & ~w_rempty;

  fifo_ptr #(.W(ADDR_WD + 1)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_we),
    .o_ptr (w_wptr)
  );

  fifo_ptr #(.W(ADDR_WD + 1)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_re),
    .o_ptr (w_rptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_we, w_re})
        2'b10:   r_count <= r_count + (ADDR_WD+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WD+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.mem_winc     = w_we;
  assign bus.waddr        = w_wptr[ADDR_WD-1:0];
  assign bus.raddr        = w_rptr[ADDR_WD-1:0];
  assign bus.wfull        = w_wfull;
  assign bus.rempty       = w_rempty;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= AFULL_C);
  assign bus.almost_empty = (r_count <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky: once a request is rejected the flag holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.winc && w_wfull)  r_overflow  <= 1'b1;
      if (bus.rinc && w_rempty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

`ifdef SYNC_FIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.ADDR_WD(AW)) bus ();

  sync_fifo_ctrl #(
    .ADDR_WD   (AW),
    .AFULL_TH  (AF),
    .AEMPTY_TH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the dual-port mem: synchronous write, combinational read.
  logic [7:0] mem [DEPTH];
  logic [7:0] wdata;
  logic [7:0] rdata;
  always @(posedge clk) if (bus.mem_winc) mem[bus.waddr] <= wdata;
  assign rdata = mem[bus.raddr];

  // Reference model: queue of stored words plus accepted-transfer tallies.
  logic [7:0] q[$];
  int  wacc, racc;
  bit  ovf, unf;
  bit  model_ok = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input bit rd, input logic [7:0] d);
    int  n;
    bit  full, empty;
    rst      = r;
    bus.winc = w;
    bus.rinc = rd;
    wdata    = d;
    #1;
    n = q.size();
    if (model_ok) begin
      check("rempty",       32'(bus.rempty),       32'(n == 0));
      check("wfull",        32'(bus.wfull),        32'(n == DEPTH));
      check("count",        32'(bus.count),        32'(n));
      check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
      check("waddr",        32'(bus.waddr),        32'(wacc % DEPTH));
      check("raddr",        32'(bus.raddr),        32'(racc % DEPTH));
      check("mem_winc",     32'(bus.mem_winc),     32'(w && (n != DEPTH)));
      check("overflow",     32'(bus.overflow),     32'(ERR_EN && ovf));
      check("underflow",    32'(bus.underflow),    32'(ERR_EN && unf));
      if (n > 0) check("rdata", 32'(rdata), 32'(q[0]));
    end
    if (r) begin
      q.delete();
      wacc = 0; racc = 0; ovf = 1'b0; unf = 1'b0;
      model_ok = 1'b1;
    end else begin
      full  = (n == DEPTH);
      empty = (n == 0);
      if (w && full)   ovf = 1'b1;
      if (rd && empty) unf = 1'b1;
      if (rd && !empty) begin void'(q.pop_front()); racc++; end
      if (w && !full)   begin q.push_back(d); wacc++; end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         rst;
    bit         winc;
    bit         rinc;
    logic [7:0] wdata;
    int         exp_count;
    bit         exp_empty;
    logic [7:0] exp_head;
    bit         exp_unf;
  } vec_t;

  vec_t tbl[10];
  cnt_t saved;

  initial begin
    rst = 1'b1; bus.winc = 1'b0; bus.rinc = 1'b0; wdata = '0;

    // Expected state after each edge, derived by hand.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h11, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h11, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b0, 8'h22, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 8'h33, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b0, 8'h44, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b1};

    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].winc, tbl[i].rinc, tbl[i].wdata);
      check("tbl_count",  32'(bus.count),     32'(tbl[i].exp_count));
      check("tbl_empty",  32'(bus.rempty),    32'(tbl[i].exp_empty));
      check("tbl_unf",    32'(bus.underflow), 32'(tbl[i].exp_unf && ERR_EN));
      if (!tbl[i].exp_empty) check("tbl_head", 32'(rdata), 32'(tbl[i].exp_head));
    end
    check("tbl_reset_waddr", 32'(bus.waddr), 32'(4));

    // Fill to full, then one rejected write.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(i));
      if (i + 1 == AF - 1) check("af_not_yet", 32'(bus.almost_full), 32'(0));
      if (i + 1 == AF)     check("af_first",   32'(bus.almost_full), 32'(1));
    end
    check("fill_full",  32'(bus.wfull), 32'(1));
    check("fill_count", 32'(bus.count), 32'(DEPTH));
    bus.winc = 1'b1; #1;
    check("full_no_write", 32'(bus.mem_winc), 32'(0));
    cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    check("ovf_count", 32'(bus.count),    32'(DEPTH));
    check("ovf_flag",  32'(bus.overflow), 32'(ERR_EN));

    // Drain in order, then one rejected pop.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(rdata), 32'(i));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(bus.rempty), 32'(1));
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("unf_flag",  32'(bus.underflow), 32'(ERR_EN));
    check("unf_count", 32'(bus.count),     32'(0));

    // Simultaneous push/pop at full and at empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b0, 1'b1, 1'b1, 8'hEE);
    check("sim_full_count", 32'(bus.count), 32'(DEPTH - 1));
    check("sim_full_wfull", 32'(bus.wfull), 32'(0));
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("sim_pre_empty", 32'(bus.rempty), 32'(1));
    saved = cnt_t'(bus.raddr);
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    check("sim_empty_count", 32'(bus.count), 32'(1));
    check("sim_empty_rdata", 32'(rdata),     32'(8'h5A));
    check("sim_empty_raddr", 32'(bus.raddr), 32'(saved));

    // Steady streaming across pointer wrap.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'(8'h80 + i));
      check("wrap_count", 32'(bus.count), 32'(3));
    end
    check("wrap_head", 32'(rdata), 32'(8'h80 + 37));

    // Reset in the middle of operation.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
    check("mid_pre_count", 32'(bus.count), 32'(9));
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("mid_count",  32'(bus.count),     32'(0));
    check("mid_empty",  32'(bus.rempty),    32'(1));
    check("mid_ovf",    32'(bus.overflow),  32'(0));
    check("mid_unf",    32'(bus.underflow), 32'(0));
    cycle(1'b0, 1'b1, 1'b0, 8'hA5);
    check("mid_rdata",  32'(rdata), 32'(8'hA5));

    // Randomized traffic with phases biased toward full, empty and balanced.
    for (int p = 0; p < 15; p++) begin
      int wp;
      int rp;
      wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int c = 0; c < 150; c++) begin
        cycle($urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < wp,
              $urandom_range(0, 99) < rp,
              8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port `mem` array. It owns the write and read pointers and drives `mem`'s write enable, `waddr` and `raddr`. It also produces `wfull`, `rempty`, occupancy, almost-full/almost-empty thresholds and error flags. It pairs with `mem` inside a `sync_fifo` top level, which is the single-clock counterpart of the async FIFO.

Parameters:
ADDR_WD, 4, address width; DEPTH = 1 << ADDR_WD entries.
AFULL_TH, 14, almost_full asserts when count >= AFULL_TH (legal range 1..DEPTH).
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (legal range 0..DEPTH-1).

Ports:
clk  in  1  sole clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
winc  in  1  write request.
rinc  in  1  read request (pop).
mem_winc  out  1  write enable to mem; equals winc & !wfull.
waddr  out  ADDR_WD  write address to mem; low bits of wptr.
raddr  out  ADDR_WD  read address to mem; low bits of rptr.
wfull  out  1  FIFO full; also routed to mem.wfull.
rempty  out  1  FIFO empty.
count  out  ADDR_WD+1  occupancy, 0..DEPTH.
almost_full  out  1  count >= AFULL_TH.
almost_empty  out  1  count <= AEMPTY_TH.
overflow  out  1  sticky; write attempted while full.
underflow  out  1  sticky; read attempted while empty.

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: wptr = 0, rptr = 0, count = 0, overflow = 0, underflow = 0.
  - Hence rempty = 1, wfull = 0, almost_empty = 1, almost_full = 0, waddr = raddr = 0.
- Reset mid-operation discards all contents. Mem contents are not cleared and are don't-care.
- Pointers are ADDR_WD+1 bits wide, binary, and wrap naturally modulo 2^(ADDR_WD+1).
- Flags are combinational from the registered pointers, so they reflect state at the start of the cycle:
  - rempty = (wptr == rptr).
  - wfull = (wptr[MSB] != rptr[MSB]) && (wptr[ADDR_WD-1:0] == rptr[ADDR_WD-1:0]).
- Write accept: we = winc & !wfull. On accept, mem[waddr] is written at the edge and wptr increments.
- Read accept: re = rinc & !rempty. rptr increments at the edge.
- Read data (show-ahead): mem read is combinational at raddr, so rdata is the head entry whenever rempty = 0. A pop consumes the displayed word; there is no extra read latency.
- Write-to-read latency: 1 cycle. rempty deasserts the cycle after the first accepted write, with the written data already on rdata.
- Simultaneous winc and rinc:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read accepted, write rejected (overflow sets); count becomes DEPTH-1.
  - Empty: write accepted, read rejected (underflow sets); count becomes 1.
- count is registered: count + we - re. It equals wptr - rptr (ADDR_WD+1 bits) at all times.
- almost_full and almost_empty are combinational from count.
- overflow sets on winc & wfull; underflow sets on rinc & rempty. Both clear only on rst.
- Rejected requests never move pointers and never write mem.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAG_EN.
- Defined: overflow and underflow behave as specified above.
- Undefined: both ports are tied to 0, and their registers and logic are not built.

Decomposition:
- Package fifo_pkg holds:
  - DEPTH derivation as a function of ADDR_WD;
  - a pointer typedef of ADDR_WD+1 bits;
  - a count typedef of ADDR_WD+1 bits.
- One sub-module, fifo_ptr: a wrapping pointer register with synchronous reset and increment enable, instantiated twice (write and read).
- Full/empty comparison and count logic stay in sync_fifo_ctrl.
- Top-level sync_fifo instantiates sync_fifo_ctrl plus mem.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles -> rempty = 1, wfull = 0, count = 0, waddr = raddr = 0, almost_empty = 1, flags = 0.
2. Fill: 16 writes of 0x00..0x0F with rinc = 0 -> after 16 edges wfull = 1, count = 16. almost_full first asserts at count = 14. A 17th winc gives mem_winc = 0, count stays 16, overflow = 1.
3. Drain: from full, 16 pops -> rdata sequence 0x00..0x0F, each valid before its pop. rempty = 1 after the 16th. A further rinc sets underflow = 1 and leaves count = 0.
4. Simultaneous at full and at empty:
   - full with winc = rinc = 1 -> count = 15, wfull = 0, no mem write;
   - empty with winc = rinc = 1 -> count = 1, rdata = written value next cycle, rptr unchanged.
5. Wrap-around: 40 cycles of steady winc = rinc = 1 after 3 prewrites -> count holds 3. Pointers wrap past 31 to 0; data order is preserved; no spurious wfull or rempty.
6. Mid-operation reset: count = 9, then rst pulse for 1 cycle -> the next cycle shows count = 0, rempty = 1, overflow = underflow = 0. A subsequent write of 0xA5 reads back 0xA5.
